input_handshake_unit: RTL and testbench
=======================================

# input_handshake_unit

Debounced user-input front end for the processing unit. It synchronizes and debounces the board's confirm push-button, latches the 18 switches on a confirmed press, and handshakes the value into the processor's input path. While the processor is executing an input instruction, `input_request` is high and the block holds `stall` high until the user confirms. A single-cycle `input_valid` then lets exactly one input instruction complete.

## Interface
- `DEBOUNCE_CYCLES`, 50000: consecutive stable cycles required before a button level change is accepted; must be ≥2.
- `COUNTER_WIDTH`, 16: width of the debounce counter; must hold `DEBOUNCE_CYCLES-1`.
- `clock` in 1: single clock, all state updates on rising edge.
- `reset` in 1: synchronous, active-low; sampled on `clock` rising edge.
- `button` in 1: raw asynchronous push-button, active-low (pressed = 0).
- `switches` in 18: raw switch levels, sampled only when a press is accepted.
- `input_request` in 1: high while the current instruction is an input instruction.
- `input_data` out 32: latched switches, zero-extended (`{14'b0, switches}`).
- `input_valid` out 1: high for exactly one cycle when `input_data` is delivered.
- `stall` out 1: freeze the processor (PC hold, no register write).
- `waiting` out 1: high in ARMED; drives a board LED.

## Operation
- Synchronizer: two flops `sync1`→`sync2` on `button`. Both reset to 1.
- Debounce: `stable` register (reset 1), counter (reset 0).
  - If `sync2 == stable`, the counter clears.
  - Otherwise, if counter `== DEBOUNCE_CYCLES-1`, `stable <= sync2` and the counter clears.
  - Otherwise the counter increments.
- Press event (combinational): `stable==1`, `sync2==0`, and counter `== DEBOUNCE_CYCLES-1`, i.e. the cycle in which `stable` falls.
- FSM states are IDLE, ARMED, DELIVER and RELEASE. Reset state is IDLE.
  - **IDLE**: if `input_request` is high, go to ARMED. A press event in IDLE is ignored and discarded, even in the same cycle that `input_request` rises.
  - **ARMED**: on a press event, `input_data <= {14'b0, switches}` and go to DELIVER. If `input_request` drops (abort), go to IDLE with `input_data` unchanged. If both happen in the same cycle, the press wins (go to DELIVER).
  - **DELIVER**: lasts exactly one cycle, then always go to RELEASE, regardless of `input_request`.
  - **RELEASE**: when `stable==1` (button released), go to IDLE. Back-to-back input instructions therefore each require a fresh press.
- Outputs:
  - `input_valid` = (state==DELIVER).
  - `stall` = `input_request` && (state != DELIVER). This is combinational, so it is asserted in the same cycle the request appears.
  - `waiting` = (state==ARMED).
- Reset values: `input_data`=0, `input_valid`=0, `waiting`=0, state IDLE, `stable`/`sync1`/`sync2`=1, counter=0. `stall` equals `input_request` during reset.
- Reset mid-operation (any state): returns to the reset values at that edge, and any partially counted debounce is discarded.
- Glitches: a `sync2` mismatch shorter than `DEBOUNCE_CYCLES` cycles never changes `stable`, because the counter restarts on every return to the stable level.

## Timing
- Button-press latency, counting from the first rising edge that samples `button` low:
  - edge 1 captures it in `sync1`;
  - edge 2 captures it in `sync2`;
  - the press event is asserted after edge `DEBOUNCE_CYCLES+1`;
  - DELIVER (`input_valid`=1, `stall`=0) becomes visible after edge `DEBOUNCE_CYCLES+2`. The button must be held continuously throughout.
- Release is debounced identically: `stable` rises `DEBOUNCE_CYCLES+2` edges after `button` returns high.
- `input_data` changes only on the edge entering DELIVER. It is stable during DELIVER and holds until the next accepted press or reset.
- `input_valid` is never high for two consecutive cycles.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4.
- **Reset**: hold `reset`=0 for 3 edges with `button`=0 and `input_request`=1 -> `input_data`=0, `input_valid`=0, `waiting`=0, `stall`=1. After release, the FSM goes to ARMED on the next edge.
- **Basic handshake**: `input_request`=1, `switches`=18'h2A5A5, `button` low for 10 cycles -> `stall`=1 and `waiting`=1 until edge 6 after the press. Then `input_valid`=1, `stall`=0 and `input_data`=32'h0002A5A5 for exactly one cycle. With the request still high, `stall` returns to 1 in RELEASE.
- **Bounce rejection**: in ARMED, drive `button` low 3 cycles, high 1, low 3, high -> no `input_valid` and `input_data` unchanged. A subsequent 8-cycle press delivers.
- **Back-to-back**: keep `input_request`=1 across two presses of `switches`=5 then 9, with a full release between them -> two single-cycle `input_valid` pulses delivering 5 then 9. Holding the button without a release yields only one pulse.
- **Abort and stale press**: press accepted while in IDLE (no request), then raise the request while the button is still held -> no delivery until release and re-press. A request dropped in ARMED -> IDLE, `stall`=0, `input_data` retained.
- **Reset mid-debounce**: `reset`=0 at edge 4 of a press -> no `input_valid`, counter cleared. The press must restart its full 6-edge latency.

Source files
------------

// File: rtl/input_handshake_unit.sv
// Debounced confirm-button front end: latches the switches on an accepted press
// and hands exactly one value to a waiting input instruction.
module input_handshake_unit #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int COUNTER_WIDTH   = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        button,
    input  logic [17:0] switches,
    input  logic        input_request,
    output logic [31:0] input_data,
    output logic        input_valid,
    output logic        stall,
    output logic        waiting
);

    localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = COUNTER_WIDTH'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        DELIVER = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t                   state;
    state_t                   next_state;
    logic                     sync1;
    logic                     sync2;
    logic                     stable;
    logic [COUNTER_WIDTH-1:0] count;
    logic                     press_event;

    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= button;
            sync2 <= sync1;
        end
    end

    // Counter restarts whenever sync2 returns to the accepted level, so short glitches never land.
    always_ff @(posedge clock) begin
        if (!reset) begin
            stable <= 1'b1;
            count  <= '0;
        end else if (sync2 == stable) begin
            count <= '0;
        end else if (count == CNT_MAX) begin
            stable <= sync2;
            count  <= '0;
        end else begin
            count <= count + COUNTER_WIDTH'(1);
        end
    end

    assign press_event = stable && !sync2 && (count == CNT_MAX);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        input_valid = 1'b0;
        waiting     = 1'b0;
        stall       = input_request;
        case (state)
            IDLE: begin
                if (input_request) next_state = ARMED;
            end
            ARMED: begin
                waiting = 1'b1;
                // A press arriving with the abort still delivers.
                if (press_event)         next_state = DELIVER;
                else if (!input_request) next_state = IDLE;
            end
            DELIVER: begin
                input_valid = 1'b1;
                stall       = 1'b0;
                next_state  = RELEASE;
            end
            RELEASE: begin
                if (stable) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            input_data <= '0;
        end else if (state == ARMED && press_event) begin
            input_data <= {14'b0, switches};
        end
    end

endmodule

// File: tb/tb_input_handshake_unit.sv
// Directed bench for input_handshake_unit with a short debounce window and a
// scoreboard of expected deliveries.
module tb_input_handshake_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        button;
    logic [17:0] switches;
    logic        input_request;
    logic [31:0] input_data;
    logic        input_valid;
    logic        stall;
    logic        waiting;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    logic        prev_valid = 1'b0;

    input_handshake_unit #(
        .DEBOUNCE_CYCLES(4),
        .COUNTER_WIDTH  (4)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .button       (button),
        .switches     (switches),
        .input_request(input_request),
        .input_data   (input_data),
        .input_valid  (input_valid),
        .stall        (stall),
        .waiting      (waiting)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wait_armed(input string tag);
        for (int i = 0; i < 20 && !waiting; i++) step(1);
        check(tag, {31'b0, waiting}, 32'd1);
    endtask

    // Every delivery must have been predicted, and pulses never touch.
    always @(negedge clock) begin
        if (input_valid) begin
            check("valid_single_cycle", {31'b0, prev_valid}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_delivery", 32'd1, 32'd0);
            end else begin
                check("sb_input_data", input_data, exp_q.pop_front());
            end
        end
        prev_valid <= input_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset         = 1'b0;
        button        = 1'b0;
        input_request = 1'b1;
        switches      = 18'h0;

        // Reset with button held and request high
        step(3);
        check("rst_data", input_data, 32'd0);
        check("rst_valid", {31'b0, input_valid}, 32'd0);
        check("rst_waiting", {31'b0, waiting}, 32'd0);
        check("rst_stall", {31'b0, stall}, 32'd1);
        reset  = 1'b1;
        button = 1'b1;
        step(1);
        check("post_rst_armed", {31'b0, waiting}, 32'd1);

        // Basic handshake
        switches = 18'h2A5A5;
        button   = 1'b0;
        exp_q.push_back(32'h0002A5A5);
        for (int i = 1; i <= 5; i++) begin
            step(1);
            check("basic_wait_waiting", {31'b0, waiting}, 32'd1);
            check("basic_wait_stall", {31'b0, stall}, 32'd1);
            check("basic_wait_valid", {31'b0, input_valid}, 32'd0);
        end
        step(1);
        check("basic_valid", {31'b0, input_valid}, 32'd1);
        check("basic_stall", {31'b0, stall}, 32'd0);
        check("basic_data", input_data, 32'h0002A5A5);
        step(1);
        check("basic_valid_drop", {31'b0, input_valid}, 32'd0);
        check("basic_release_stall", {31'b0, stall}, 32'd1);
        check("basic_release_waiting", {31'b0, waiting}, 32'd0);
        step(3);
        button = 1'b1;
        step(6);
        check("release_still_held", {31'b0, waiting}, 32'd0);
        step(1);
        check("release_idle", {31'b0, waiting}, 32'd0);
        step(1);
        check("rearmed", {31'b0, waiting}, 32'd1);

        // Bounce rejection
        button = 1'b0; step(3);
        button = 1'b1; step(1);
        button = 1'b0; step(3);
        button = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            check("bounce_no_valid", {31'b0, input_valid}, 32'd0);
        end
        check("bounce_waiting", {31'b0, waiting}, 32'd1);
        check("bounce_data_kept", input_data, 32'h0002A5A5);
        switches = 18'h3FFFF;
        button   = 1'b0;
        exp_q.push_back(32'h0003FFFF);
        step(6);
        check("long_press_valid", {31'b0, input_valid}, 32'd1);
        check("long_press_data", input_data, 32'h0003FFFF);
        step(2);
        button = 1'b1;
        wait_armed("long_press_rearm");

        // Back-to-back presses, the first held long
        switches = 18'd5;
        button   = 1'b0;
        exp_q.push_back(32'd5);
        step(6);
        check("b2b_first_valid", {31'b0, input_valid}, 32'd1);
        check("b2b_first_data", input_data, 32'd5);
        step(12);
        check("b2b_held_no_valid", {31'b0, input_valid}, 32'd0);
        check("b2b_held_not_armed", {31'b0, waiting}, 32'd0);
        button = 1'b1;
        wait_armed("b2b_rearm");
        switches = 18'd9;
        button   = 1'b0;
        exp_q.push_back(32'd9);
        step(6);
        check("b2b_second_valid", {31'b0, input_valid}, 32'd1);
        check("b2b_second_data", input_data, 32'd9);
        step(2);
        button = 1'b1;
        wait_armed("b2b_rearm2");

        // Abort in ARMED, then a press accepted while idle
        input_request = 1'b0;
        #1;
        check("abort_stall_comb", {31'b0, stall}, 32'd0);
        step(1);
        check("abort_idle", {31'b0, waiting}, 32'd0);
        check("abort_data_kept", input_data, 32'd9);
        switches = 18'h00777;
        button   = 1'b0;
        step(7);
        input_request = 1'b1;
        #1;
        check("stale_stall_comb", {31'b0, stall}, 32'd1);
        step(1);
        check("stale_armed", {31'b0, waiting}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            step(1);
            check("stale_no_valid", {31'b0, input_valid}, 32'd0);
        end
        button = 1'b1;
        step(8);
        check("stale_data_kept", input_data, 32'd9);
        switches = 18'h20000;
        button   = 1'b0;
        exp_q.push_back(32'h00020000);
        step(6);
        check("repress_valid", {31'b0, input_valid}, 32'd1);
        check("repress_data", input_data, 32'h00020000);
        step(2);
        button = 1'b1;
        wait_armed("repress_rearm");

        // Reset in the middle of a debounce
        switches = 18'h00ABC;
        button   = 1'b0;
        step(3);
        reset = 1'b0;
        step(1);
        check("midrst_data", input_data, 32'd0);
        check("midrst_valid", {31'b0, input_valid}, 32'd0);
        check("midrst_waiting", {31'b0, waiting}, 32'd0);
        check("midrst_stall", {31'b0, stall}, 32'd1);
        reset = 1'b1;
        exp_q.push_back(32'h00000ABC);
        for (int i = 1; i <= 5; i++) begin
            step(1);
            check("midrst_restart_no_valid", {31'b0, input_valid}, 32'd0);
        end
        check("midrst_restart_armed", {31'b0, waiting}, 32'd1);
        step(1);
        check("midrst_valid_after_6", {31'b0, input_valid}, 32'd1);
        check("midrst_data_after_6", input_data, 32'h00000ABC);
        step(2);
        button = 1'b1;
        step(10);

        check("sb_all_delivered", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
